// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions for the SEQ stage sequencer.
// Covers icodes, status codes, sequencer states and the memory-icode classifier.
package y86_pkg;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  localparam logic [1:0] STAT_AOK = 2'd0;
  localparam logic [1:0] STAT_HLT = 2'd1;
  localparam logic [1:0] STAT_ADR = 2'd2;
  localparam logic [1:0] STAT_INS = 2'd3;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXECUTE,
    ST_MEMORY,
    ST_WRITEBACK,
    ST_PCUPD,
    ST_HALTED,
    ST_FAULT
  } seq_state_t;

  // Only these instructions touch data memory; all others pass MEMORY in one cycle.
  function automatic logic is_mem_icode(input logic [3:0] code);
    logic result;
    case (code)
      IRMMOVQ, IMRMOVQ, ICALL, IRET, IPUSHQ, IPOPQ: result = 1'b1;
      IHALT, INOP, IRRMOVQ, IIRMOVQ, IOPQ, IJXX:    result = 1'b0;
      default:                                      result = 1'b0;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/y86_perf_cnt.sv
// Saturating event counter with enable; sticks at all-ones instead of wrapping.
module y86_perf_cnt #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/y86_seq_ctrl.sv
// Multi-cycle stage sequencer for the Y86-64 SEQ core: one stage per cycle, registered PC/status.
// Performance counters are built only when SEQ_CTRL_PERF_EN is defined.
module y86_seq_ctrl
  import y86_pkg::*;
#(
  parameter int                ADDR_W      = 64,
  parameter logic [ADDR_W-1:0] RESET_PC    = ADDR_W'(32),
  parameter int                MEM_TIMEOUT = 16,
  parameter int                CNT_W       = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic [3:0]        icode,
  input  logic              instr_valid,
  input  logic              imem_error,
  input  logic              hlt,
  input  logic              mem_ack,
  input  logic              dmem_error,
  input  logic [ADDR_W-1:0] next_pc,
  output logic [ADDR_W-1:0] pc,
  output logic              fe_en,
  output logic              de_en,
  output logic              ex_en,
  output logic              mem_en,
  output logic              wb_en,
  output logic              pc_en,
  output logic              mem_req,
  output logic [1:0]        stat,
  output logic              busy,
  output logic [CNT_W-1:0]  cycle_cnt,
  output logic [CNT_W-1:0]  instr_cnt
);

  localparam int              WAIT_W    = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  seq_state_t        state, state_nxt;
  logic [1:0]        stat_nxt;
  logic [ADDR_W-1:0] pc_nxt;
  logic              mem_op, mem_op_nxt;
  logic [WAIT_W-1:0] wait_cnt, wait_cnt_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      stat     <= STAT_AOK;
      pc       <= RESET_PC;
      mem_op   <= 1'b0;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      stat     <= stat_nxt;
      pc       <= pc_nxt;
      mem_op   <= mem_op_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  // The memory-class of the instruction is latched at the end of FETCH so that
  // mem_req can be decoded from registers only.
  always_comb begin
    state_nxt    = state;
    stat_nxt     = stat;
    pc_nxt       = pc;
    mem_op_nxt   = mem_op;
    wait_cnt_nxt = wait_cnt;
    case (state)
      ST_IDLE: begin
        if (run) state_nxt = ST_FETCH;
      end
      ST_FETCH: begin
        if (imem_error) begin
          stat_nxt  = STAT_ADR;
          state_nxt = ST_FAULT;
        end else if (!instr_valid) begin
          stat_nxt  = STAT_INS;
          state_nxt = ST_FAULT;
        end else if (hlt) begin
          stat_nxt  = STAT_HLT;
          state_nxt = ST_HALTED;
        end else begin
          mem_op_nxt = is_mem_icode(icode);
          state_nxt  = ST_DECODE;
        end
      end
      ST_DECODE:  state_nxt = ST_EXECUTE;
      ST_EXECUTE: begin
        wait_cnt_nxt = '0;
        state_nxt    = ST_MEMORY;
      end
      // An acknowledge in the final allowed wait cycle still completes the access.
      ST_MEMORY: begin
        if (!mem_op) begin
          state_nxt = ST_WRITEBACK;
        end else if (mem_ack) begin
          if (dmem_error) begin
            stat_nxt  = STAT_ADR;
            state_nxt = ST_FAULT;
          end else begin
            state_nxt = ST_WRITEBACK;
          end
        end else if (wait_cnt == WAIT_LAST) begin
          stat_nxt  = STAT_ADR;
          state_nxt = ST_FAULT;
        end else begin
          wait_cnt_nxt = wait_cnt + WAIT_W'(1);
        end
      end
      ST_WRITEBACK: state_nxt = ST_PCUPD;
      ST_PCUPD: begin
        pc_nxt    = next_pc;
        state_nxt = run ? ST_FETCH : ST_IDLE;
      end
      ST_HALTED: state_nxt = ST_HALTED;
      ST_FAULT:  state_nxt = ST_FAULT;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    fe_en   = 1'b0;
    de_en   = 1'b0;
    ex_en   = 1'b0;
    mem_en  = 1'b0;
    wb_en   = 1'b0;
    pc_en   = 1'b0;
    mem_req = 1'b0;
    busy    = 1'b1;
    case (state)
      ST_FETCH:     fe_en = 1'b1;
      ST_DECODE:    de_en = 1'b1;
      ST_EXECUTE:   ex_en = 1'b1;
      ST_MEMORY: begin
        mem_en  = 1'b1;
        mem_req = mem_op;
      end
      ST_WRITEBACK: wb_en = 1'b1;
      ST_PCUPD:     pc_en = 1'b1;
      default:      busy  = 1'b0;
    endcase
  end

`ifdef SEQ_CTRL_PERF_EN
  y86_perf_cnt #(.CNT_W(CNT_W)) u_cycle_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (busy),
    .count (cycle_cnt)
  );

  y86_perf_cnt #(.CNT_W(CNT_W)) u_instr_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (pc_en),
    .count (instr_cnt)
  );
`else
  assign cycle_cnt = '0;
  assign instr_cnt = '0;
`endif

endmodule

// File: tb/tb_y86_seq_ctrl.sv
// Self-checking bench for y86_seq_ctrl: directed scenarios with literal expectations,
// then randomized stimulus compared every cycle against a stage-index model.
`timescale 1ns/1ps
module tb_y86_seq_ctrl;

  localparam int          ADDR_W      = 64;
  localparam int          MEM_TIMEOUT = 16;
  localparam int          CNT_W       = 32;
  localparam logic [63:0] RESET_PC    = 64'd32;
`ifdef SEQ_CTRL_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              run = 1'b0;
  logic [3:0]        icode = 4'h1;
  logic              instr_valid = 1'b1;
  logic              imem_error = 1'b0;
  logic              hlt = 1'b0;
  logic              mem_ack = 1'b0;
  logic              dmem_error = 1'b0;
  logic [ADDR_W-1:0] next_pc = '0;
  logic [ADDR_W-1:0] pc;
  logic              fe_en, de_en, ex_en, mem_en, wb_en, pc_en;
  logic              mem_req, busy;
  logic [1:0]        stat;
  logic [CNT_W-1:0]  cycle_cnt, instr_cnt;
  logic [5:0]        en_vec;

  int total = 0;
  int bad   = 0;
  bit chk_on = 1'b0;

  assign en_vec = {pc_en, wb_en, mem_en, ex_en, de_en, fe_en};

  always #5 clk = ~clk;

  y86_seq_ctrl #(
    .ADDR_W(ADDR_W), .RESET_PC(RESET_PC), .MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .run(run), .icode(icode), .instr_valid(instr_valid),
    .imem_error(imem_error), .hlt(hlt), .mem_ack(mem_ack), .dmem_error(dmem_error),
    .next_pc(next_pc), .pc(pc), .fe_en(fe_en), .de_en(de_en), .ex_en(ex_en),
    .mem_en(mem_en), .wb_en(wb_en), .pc_en(pc_en), .mem_req(mem_req), .stat(stat),
    .busy(busy), .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
  );

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic applyStimulus(input bit r, input logic [3:0] ic, input logic [63:0] npc);
    run     = r;
    icode   = ic;
    next_pc = npc;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Model: mode (idle/running/halted/fault) plus stage index 0..5 within an instruction.
  localparam int M_IDLE = 0, M_RUN = 1, M_HALT = 2, M_FAULT = 3;
  int          m_mode = M_IDLE;
  int          m_stage = 0;
  int          m_wait = 0;
  bit          m_is_mem = 1'b0;
  logic [63:0] m_pc = RESET_PC;
  logic [1:0]  m_stat = 2'd0;
  logic [31:0] m_cyc = '0;
  logic [31:0] m_ins = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_mode <= M_IDLE; m_stage <= 0; m_wait <= 0; m_is_mem <= 1'b0;
      m_pc <= RESET_PC; m_stat <= 2'd0; m_cyc <= '0; m_ins <= '0;
    end else begin
      if (m_mode == M_RUN && m_cyc != '1) m_cyc <= m_cyc + 32'd1;
      case (m_mode)
        M_IDLE: if (run) begin m_mode <= M_RUN; m_stage <= 0; end
        M_RUN: begin
          case (m_stage)
            0: begin
              if (imem_error)        begin m_mode <= M_FAULT; m_stat <= 2'd2; end
              else if (!instr_valid) begin m_mode <= M_FAULT; m_stat <= 2'd3; end
              else if (hlt)          begin m_mode <= M_HALT;  m_stat <= 2'd1; end
              else begin
                m_stage  <= 1;
                m_is_mem <= (icode inside {4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB});
              end
            end
            1: m_stage <= 2;
            2: begin m_stage <= 3; m_wait <= 0; end
            3: begin
              if (!m_is_mem || (mem_ack && !dmem_error)) m_stage <= 4;
              else if (mem_ack)                          begin m_mode <= M_FAULT; m_stat <= 2'd2; end
              else if (m_wait + 1 >= MEM_TIMEOUT)        begin m_mode <= M_FAULT; m_stat <= 2'd2; end
              else m_wait <= m_wait + 1;
            end
            4: m_stage <= 5;
            default: begin
              m_pc <= next_pc;
              if (m_ins != '1) m_ins <= m_ins + 32'd1;
              if (run) m_stage <= 0;
              else     m_mode  <= M_IDLE;
            end
          endcase
        end
        default: ;
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      checkOutput("model_enables", 64'(en_vec), (m_mode == M_RUN) ? 64'(6'd1 << m_stage) : 64'd0);
      checkOutput("model_mem_req", 64'(mem_req), 64'(m_mode == M_RUN && m_stage == 3 && m_is_mem));
      checkOutput("model_busy", 64'(busy), 64'(m_mode == M_RUN));
      checkOutput("model_pc", pc, m_pc);
      checkOutput("model_stat", 64'(stat), 64'(m_stat));
      checkOutput("model_cycle_cnt", 64'(cycle_cnt), PERF ? 64'(m_cyc) : 64'd0);
      checkOutput("model_instr_cnt", 64'(instr_cnt), PERF ? 64'(m_ins) : 64'd0);
    end
  end

  initial begin
    #1ms;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n_busy, n_req, sticky, ack_pct;
    repeat (2) @(posedge clk);
    #2;
    chk_on = 1'b1;

    checkOutput("reset_pc", pc, 64'd32);
    checkOutput("reset_stat", 64'(stat), 64'd0);
    checkOutput("reset_enables", 64'(en_vec), 64'd0);
    checkOutput("reset_busy", 64'(busy), 64'd0);
    checkOutput("reset_mem_req", 64'(mem_req), 64'd0);
    checkOutput("reset_cycle_cnt", 64'(cycle_cnt), 64'd0);

    // OPq: six single-cycle stages, no memory request, pause afterwards
    rst = 1'b0;
    applyStimulus(1'b1, 4'h6, 64'd42);
    tick();
    run = 1'b0;
    for (int k = 0; k < 6; k++) begin
      checkOutput("t1_enables", 64'(en_vec), 64'(6'd1 << k));
      checkOutput("t1_mem_req", 64'(mem_req), 64'd0);
      tick();
    end
    checkOutput("t1_busy", 64'(busy), 64'd0);
    checkOutput("t1_pc", pc, 64'd42);
    checkOutput("t1_instr_cnt", 64'(instr_cnt), PERF ? 64'd1 : 64'd0);
    checkOutput("t1_cycle_cnt", 64'(cycle_cnt), PERF ? 64'd6 : 64'd0);

    // mrmovq with acknowledge on the fourth request cycle
    applyStimulus(1'b1, 4'h5, 64'd100);
    n_busy = 0; n_req = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      run = 1'b0;
      if (!busy) break;
      n_busy++;
      if (mem_req) begin n_req++; mem_ack = (n_req == 4); end
      else mem_ack = 1'b0;
    end
    mem_ack = 1'b0;
    checkOutput("t2_cycles", 64'(n_busy), 64'd9);
    checkOutput("t2_req_cycles", 64'(n_req), 64'd4);
    checkOutput("t2_stat", 64'(stat), 64'd0);
    checkOutput("t2_pc", pc, 64'd100);

    // rmmovq with no acknowledge: timeout fault
    applyStimulus(1'b1, 4'h4, 64'd555);
    n_busy = 0; n_req = 0;
    for (int c = 0; c < 60; c++) begin
      tick();
      run = 1'b0;
      if (!busy) break;
      n_busy++;
      if (mem_req) n_req++;
    end
    checkOutput("t3_req_cycles", 64'(n_req), 64'd16);
    checkOutput("t3_cycles", 64'(n_busy), 64'd19);
    checkOutput("t3_stat", 64'(stat), 64'd2);
    checkOutput("t3_pc", pc, 64'd100);
    run = 1'b1;
    repeat (3) tick();
    checkOutput("t3_sticky_busy", 64'(busy), 64'd0);
    checkOutput("t3_sticky_enables", 64'(en_vec), 64'd0);

    // imem_error has priority over an illegal instruction
    run = 1'b0;
    pulse_reset();
    imem_error = 1'b1; instr_valid = 1'b0;
    applyStimulus(1'b1, 4'h6, 64'd77);
    tick(); tick();
    checkOutput("t4_adr_stat", 64'(stat), 64'd2);
    checkOutput("t4_adr_busy", 64'(busy), 64'd0);
    imem_error = 1'b0; instr_valid = 1'b1;

    // halt: sticky, PC untouched, run ignored
    run = 1'b0;
    pulse_reset();
    hlt = 1'b1;
    applyStimulus(1'b1, 4'h0, 64'd77);
    tick(); tick();
    checkOutput("t4_hlt_stat", 64'(stat), 64'd1);
    checkOutput("t4_hlt_pc", pc, 64'd32);
    repeat (4) tick();
    checkOutput("t4_hlt_busy", 64'(busy), 64'd0);
    checkOutput("t4_hlt_enables", 64'(en_vec), 64'd0);
    checkOutput("t4_hlt_pc_later", pc, 64'd32);
    hlt = 1'b0;

    // reset during the second memory wait cycle
    run = 1'b0;
    pulse_reset();
    applyStimulus(1'b1, 4'h8, 64'd900);
    repeat (5) tick();
    checkOutput("t5_waiting", 64'(mem_req), 64'd1);
    rst = 1'b1;
    #1;
    checkOutput("t5_async_mem_req", 64'(mem_req), 64'd0);
    checkOutput("t5_async_busy", 64'(busy), 64'd0);
    checkOutput("t5_async_enables", 64'(en_vec), 64'd0);
    checkOutput("t5_async_pc", pc, 64'd32);
    tick();
    rst = 1'b0;
    applyStimulus(1'b1, 4'h6, 64'd200);
    tick();
    checkOutput("t5_resume_fetch", 64'(fe_en), 64'd1);
    checkOutput("t5_resume_pc", pc, 64'd32);

    // run dropped in EXECUTE: completes then idles; resumes at the new pc
    tick(); tick();
    checkOutput("t6_in_execute", 64'(ex_en), 64'd1);
    run = 1'b0;
    repeat (4) tick();
    checkOutput("t6_idle_busy", 64'(busy), 64'd0);
    checkOutput("t6_idle_pc", pc, 64'd200);
    tick(); tick();
    checkOutput("t6_still_idle", 64'(busy), 64'd0);
    applyStimulus(1'b1, 4'h6, 64'd300);
    tick();
    checkOutput("t6_resume_fetch", 64'(fe_en), 64'd1);
    checkOutput("t6_resume_pc", pc, 64'd200);

    // randomized phase, checked every cycle by the model
    sticky = 0; ack_pct = 40;
    for (int c = 0; c < 4000; c++) begin
      if (c % 250 == 0) begin
        case ($urandom_range(0, 2))
          0:       ack_pct = 5;
          1:       ack_pct = 40;
          default: ack_pct = 90;
        endcase
      end
      tick();
      if (rst) begin
        rst = 1'b0;
      end else if (m_mode == M_HALT || m_mode == M_FAULT) begin
        sticky++;
        if (sticky > 3) begin rst = 1'b1; sticky = 0; end
      end else if ($urandom_range(0, 499) == 0) begin
        rst = 1'b1;
      end
      run         = ($urandom_range(0, 9) != 0);
      icode       = 4'($urandom_range(0, 11));
      instr_valid = ($urandom_range(0, 29) != 0);
      imem_error  = ($urandom_range(0, 39) == 0);
      hlt         = ($urandom_range(0, 29) == 0);
      mem_ack     = ($urandom_range(0, 99) < ack_pct);
      dmem_error  = ($urandom_range(0, 19) == 0);
      next_pc     = {32'($urandom), 32'($urandom)};
    end

    tick();
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/y86_seq_ctrl.md
# y86_seq_ctrl

Multi-cycle stage sequencer for the Y86-64 SEQ processor. It replaces free-running combinational PC feedback with a registered PC and a state machine that enables fetch, decode, execute, memory, writeback and PC update one stage per cycle. It adds a data-memory ready/ack handshake with a timeout, a registered processor status, and optional performance counters. It sits in the processor top between the stage modules and the program counter.

## Interface
Parameters:
- ADDR_W, 64: PC width.
- RESET_PC, 32: PC value loaded on reset.
- MEM_TIMEOUT, 16: maximum wait cycles for mem_ack before an address fault; must be ≥1.
- CNT_W, 32: performance counter width.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- run  in  1  start/continue execution.
- icode  in  4  instruction code from fetch.
- instr_valid  in  1  1 = fetched instruction is legal.
- imem_error  in  1  instruction fetch address error.
- hlt  in  1  fetched instruction is halt.
- mem_ack  in  1  data memory completed the access.
- dmem_error  in  1  data memory address error; sampled only with mem_ack.
- next_pc  in  ADDR_W  PC from the pc_update stage.
- pc  out  ADDR_W  registered program counter.
- fe_en, de_en, ex_en, mem_en, wb_en, pc_en  out  1 each  one-hot stage enables.
- mem_req  out  1  data memory request.
- stat  out  2  status: 0 AOK, 1 HLT, 2 ADR, 3 INS.
- busy  out  1  high in every state except IDLE, HALTED and FAULT.
- cycle_cnt, instr_cnt  out  CNT_W each  performance counters.

## Operation
- States: IDLE, FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, PCUPD, HALTED, FAULT.
- IDLE → FETCH when run=1. Otherwise stay in IDLE.
- FETCH: fe_en=1. Exception checks at the end of FETCH, highest priority first:
  - imem_error → stat=ADR, go to FAULT.
  - !instr_valid → stat=INS, go to FAULT.
  - hlt → stat=HLT, go to HALTED.
  - none of the above → DECODE.
  - In all three exception cases pc is unchanged.
- DECODE → EXECUTE → MEMORY, one cycle each, with the matching enable high.
- MEMORY:
  - Memory icodes are 4, 5, 8, 9, A and B.
  - For a memory icode, mem_en=1 and mem_req=1 until mem_ack is seen.
  - For a non-memory icode, mem_en=1 and mem_req=0, and the state leaves after one cycle.
  - mem_ack with dmem_error=0 → WRITEBACK.
  - mem_ack with dmem_error=1 → stat=ADR, go to FAULT.
- Timeout:
  - A wait counter resets on entry to MEMORY and increments each cycle mem_req is high without mem_ack.
  - When the count reaches MEM_TIMEOUT: stat=ADR, go to FAULT.
  - If mem_ack arrives in the same cycle as the timeout, mem_ack wins.
- WRITEBACK → PCUPD.
- PCUPD: pc_en=1 and pc <= next_pc. Then go to FETCH if run=1, or IDLE if run=0. Deasserting run mid-instruction therefore pauses only at an instruction boundary.
- HALTED and FAULT are sticky. They exit only through rst. All enables and mem_req are 0 in these states.
- stat stays AOK until the first exception and then holds its value.

## Timing
- Reset values: pc=RESET_PC, state=IDLE, stat=AOK, all enables=0, mem_req=0, busy=0, counters=0.
- Reset is asynchronous: it takes effect immediately, even mid-instruction or during a memory wait. mem_req drops without waiting for mem_ack.
- All outputs are registered or decoded from the registered state only. There is no combinational path from any input to any output.
- Minimum instruction latency is 6 cycles from FETCH to PCUPD. Each cycle of mem_ack delay adds one cycle.
- The new pc is visible the cycle after PCUPD, which is the cycle of the next FETCH.
- mem_req rises on the first MEMORY cycle. It falls the cycle after mem_ack is sampled high.

## Configuration
- SEQ_CTRL_PERF_EN:
  - Defined: cycle_cnt increments on every busy cycle. instr_cnt increments on each PCUPD. Both saturate at all-ones.
  - Undefined: both counters are constant 0 and no counter flops are built.

## Structure
- Shared package y86_pkg holds:
  - icode constants (IHALT=0 … IPOPQ=B);
  - the stat codes STAT_AOK/HLT/ADR/INS;
  - the state enum;
  - an is_mem_icode function.
- One natural sub-module, y86_perf_cnt: a saturating CNT_W counter with enable. It is instantiated twice, only under SEQ_CTRL_PERF_EN.

## Test plan
- Reset, then run=1 with icode=6 (OPq), valid, next_pc=42: enables step FE→DE→EX→MEM→WB→PC in 6 cycles; mem_req=0; pc=42 afterwards; instr_cnt=1, cycle_cnt=6.
- icode=5 (mrmovq), mem_ack delayed 3 cycles: mem_req high for 4 cycles; instruction takes 9 cycles; stat=AOK.
- icode=4, mem_ack never arrives, MEM_TIMEOUT=16: after 16 wait cycles, stat=ADR, state FAULT, busy=0, pc unchanged.
- imem_error=1 and instr_valid=0 together in FETCH: stat=ADR (ADR has priority over INS). Separately, hlt=1: stat=HLT, HALTED, PC not updated, run ignored afterwards.
- rst asserted in the 2nd cycle of a MEMORY wait: outputs return to reset values immediately; after release with run=1, FETCH resumes at pc=32.
- run dropped during EXECUTE: the instruction completes through PCUPD, then the block returns to IDLE; raising run again resumes at next_pc.
